// File: rtl/neuron_pkg.sv
// Shared types and constants for the neuron datapath stages.
package neuron_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int SIZE_VMEM_DEF = 16;
    localparam logic signed [SIZE_VMEM_DEF-1:0] VMEM_MAX = {1'b0, {(SIZE_VMEM_DEF-1){1'b1}}};
    localparam logic signed [SIZE_VMEM_DEF-1:0] VMEM_MIN = {1'b1, {(SIZE_VMEM_DEF-1){1'b0}}};

endpackage

// File: rtl/sat_add_signed.sv
// Signed adder that clamps to the representable range of WIDTH bits.
module sat_add_signed #(
    parameter int WIDTH = 16
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [WIDTH-1:0] sum,
    output logic                    sat
);

    logic signed [WIDTH:0] w_full;

    assign w_full = {a[WIDTH-1], a} + {b[WIDTH-1], b};

    // Out of range exactly when the two top bits of the wide sum disagree.
    always_comb begin
        sat = w_full[WIDTH] ^ w_full[WIDTH-1];
        sum = w_full[WIDTH-1:0];
        if (sat) begin
            if (w_full[WIDTH]) sum = {1'b1, {(WIDTH-1){1'b0}}};
            else               sum = {1'b0, {(WIDTH-1){1'b1}}};
        end
    end

endmodule

// File: rtl/neuron_accumulate.sv
// Timestep accumulator: loads the membrane value, adds the weights of spiking
// beats with saturation and hands the result to the neuron with an update strobe.
//
// state | meaning
// IDLE  | waiting for start, beats not taken
// ACCUM | taking beats until the one marked last
// DONE  | registering impulse and raising update for one cycle
module neuron_accumulate
    import neuron_pkg::*;
#(
    parameter int size_data  = 8,
    parameter int size_vmem  = 16,
    parameter int size_count = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [size_vmem-1:0]  vmem_in,
    input  logic                  weight_valid,
    input  logic [size_data-1:0]  weight,
    input  logic                  spike_in,
    input  logic                  last,
    output logic                  weight_ready,
    output logic [size_vmem-1:0]  impulse,
    output logic                  update,
    output logic                  busy,
    output logic [size_count-1:0] beat_count,
    output logic                  overflow
);

    state_t                r_state;
    logic [size_vmem-1:0]  r_acc;
    logic [size_vmem-1:0]  r_impulse;
    logic                  r_update;
    logic [size_count-1:0] r_beat_count;
    logic                  r_overflow;

    logic [size_vmem-1:0]  w_weight_ext;
    logic [size_vmem-1:0]  w_sum;
    logic                  w_sat;
    logic                  w_accept;

    assign w_weight_ext = {{(size_vmem-size_data){weight[size_data-1]}}, weight};
    assign w_accept     = weight_valid && (r_state == ACCUM);

    sat_add_signed #(.WIDTH(size_vmem)) u_sat_add (
        .a   (r_acc),
        .b   (w_weight_ext),
        .sum (w_sum),
        .sat (w_sat)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_acc        <= '0;
            r_impulse    <= '0;
            r_update     <= 1'b0;
            r_beat_count <= '0;
            r_overflow   <= 1'b0;
        end else begin
            r_update <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_acc        <= vmem_in;
                        r_beat_count <= '0;
                        r_overflow   <= 1'b0;
                        r_state      <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (w_accept) begin
                        r_beat_count <= r_beat_count + size_count'(1);
                        if (&r_beat_count) r_overflow <= 1'b1;
                        if (spike_in) begin
                            r_acc <= w_sum;
                            if (w_sat) r_overflow <= 1'b1;
                        end
                        if (last) r_state <= DONE;
                    end
                end
                DONE: begin
                    r_impulse <= r_acc;
                    r_update  <= 1'b1;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign weight_ready = (r_state == ACCUM);
    assign busy         = (r_state != IDLE);
    assign impulse      = r_impulse;
    assign update       = r_update;
    assign beat_count   = r_beat_count;
    assign overflow     = r_overflow;

endmodule

// File: tb/tb_neuron_accumulate.sv
// Directed bench for neuron_accumulate with hand-computed expected results.
module tb_neuron_accumulate;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [15:0] vmem_in = '0;
    logic        weight_valid = 1'b0;
    logic [7:0]  weight = '0;
    logic        spike_in = 1'b0;
    logic        last = 1'b0;
    logic        weight_ready;
    logic [15:0] impulse;
    logic        update;
    logic        busy;
    logic [9:0]  beat_count;
    logic        overflow;

    int n_checks = 0;
    int n_fail   = 0;

    logic        upd_pre, upd_at, upd_post, rdy_done, busy_done, ov_at;
    logic [15:0] imp_at;
    logic [9:0]  cnt_at;

    neuron_accumulate #(.size_data(8), .size_vmem(16), .size_count(10)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .vmem_in      (vmem_in),
        .weight_valid (weight_valid),
        .weight       (weight),
        .spike_in     (spike_in),
        .last         (last),
        .weight_ready (weight_ready),
        .impulse      (impulse),
        .update       (update),
        .busy         (busy),
        .beat_count   (beat_count),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    task automatic do_start(input int v);
        @(posedge clk); #1;
        start   = 1'b1;
        vmem_in = 16'(v);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Presents one beat and returns just after the edge that accepts it.
    task automatic beat(input int w, input logic s, input logic l, input logic hold);
        logic got;
        got          = 1'b0;
        weight_valid = 1'b1;
        weight       = 8'(w);
        spike_in     = s;
        last         = l;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (weight_ready) begin
                got = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        if (!hold) weight_valid = 1'b0;
        last = 1'b0;
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL beat_accept_timeout: weight_ready never seen, required 1");
        end
    endtask

    // Observes the DONE cycle, the update cycle and the cycle after it.
    task automatic wait_done();
        @(negedge clk);
        upd_pre   = update;
        rdy_done  = weight_ready;
        busy_done = busy;
        @(negedge clk);
        upd_at = update;
        imp_at = impulse;
        cnt_at = beat_count;
        ov_at  = overflow;
        @(negedge clk);
        upd_post = update;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({impulse, update, busy, weight_ready, beat_count, overflow} !== 30'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: impulse=%h update=%b busy=%b ready=%b count=%0d ov=%b, required all 0",
                     impulse, update, busy, weight_ready, beat_count, overflow);
        end
        weight_valid = 1'b1;
        repeat (3) @(negedge clk);
        weight_valid = 1'b0;
        n_checks++;
        if (beat_count !== 10'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_ignores_beats: count=%0d busy=%b, required 0 0", beat_count, busy);
        end
    endtask

    task automatic test_basic();
        do_start(100);
        beat(50, 1, 0, 0);
        beat(60, 1, 0, 0);
        beat(127, 0, 0, 0);
        beat(10, 1, 1, 0);
        wait_done();
        n_checks++;
        if (imp_at !== 16'd220) begin
            n_fail++; $display("FAIL basic_impulse: got %0d, required 220", $signed(imp_at));
        end
        n_checks++;
        if ({upd_pre, upd_at, upd_post} !== 3'b010) begin
            n_fail++; $display("FAIL basic_update_pulse: got %b, required 010", {upd_pre, upd_at, upd_post});
        end
        n_checks++;
        if (cnt_at !== 10'd4 || ov_at !== 1'b0) begin
            n_fail++; $display("FAIL basic_count_ov: count=%0d ov=%b, required 4 0", cnt_at, ov_at);
        end
    endtask

    task automatic test_negative();
        do_start(5);
        beat(-20, 1, 0, 0);
        beat(-3, 1, 1, 0);
        wait_done();
        n_checks++;
        if (imp_at !== 16'hFFEE || cnt_at !== 10'd2 || ov_at !== 1'b0) begin
            n_fail++;
            $display("FAIL negative_sum: impulse=%h count=%0d ov=%b, required ffee 2 0", imp_at, cnt_at, ov_at);
        end
    endtask

    task automatic test_saturation();
        do_start(32700);
        beat(127, 1, 0, 0);
        beat(127, 1, 1, 0);
        wait_done();
        n_checks++;
        if (imp_at !== 16'h7FFF || ov_at !== 1'b1) begin
            n_fail++; $display("FAIL sat_positive: impulse=%h ov=%b, required 7fff 1", imp_at, ov_at);
        end
        do_start(-32768);
        n_checks++;
        if (overflow !== 1'b0) begin
            n_fail++; $display("FAIL sat_ov_cleared_on_start: ov=%b, required 0", overflow);
        end
        beat(-1, 1, 1, 0);
        wait_done();
        n_checks++;
        if (imp_at !== 16'h8000 || ov_at !== 1'b1) begin
            n_fail++; $display("FAIL sat_negative: impulse=%h ov=%b, required 8000 1", imp_at, ov_at);
        end
    endtask

    task automatic test_backpressure();
        do_start(0);
        beat(1, 1, 0, 0);
        repeat (2) @(posedge clk);
        #1 start = 1'b1;
        vmem_in = 16'd999;
        @(posedge clk); #1 start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || beat_count !== 10'd1) begin
            n_fail++; $display("FAIL start_in_accum: busy=%b count=%0d, required 1 1", busy, beat_count);
        end
        beat(2, 1, 0, 0);
        @(posedge clk); #1;
        beat(3, 1, 1, 1);
        wait_done();
        n_checks++;
        if (rdy_done !== 1'b0 || busy_done !== 1'b1) begin
            n_fail++; $display("FAIL done_ready: ready=%b busy=%b, required 0 1", rdy_done, busy_done);
        end
        n_checks++;
        if ({upd_pre, upd_at, upd_post} !== 3'b010 || imp_at !== 16'd6) begin
            n_fail++;
            $display("FAIL bp_result: pulse=%b impulse=%0d, required 010 6", {upd_pre, upd_at, upd_post}, imp_at);
        end
        repeat (3) @(negedge clk);
        weight_valid = 1'b0;
        n_checks++;
        if (beat_count !== 10'd3 || busy !== 1'b0) begin
            n_fail++; $display("FAIL valid_held_after_done: count=%0d busy=%b, required 3 0", beat_count, busy);
        end
    endtask

    task automatic test_count_wrap();
        do_start(0);
        weight_valid = 1'b1;
        weight       = 8'd5;
        spike_in     = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            last = (i == 1023);
            @(posedge clk); #1;
        end
        weight_valid = 1'b0;
        last         = 1'b0;
        wait_done();
        n_checks++;
        if (cnt_at !== 10'd0 || ov_at !== 1'b1 || imp_at !== 16'd0 || upd_at !== 1'b1) begin
            n_fail++;
            $display("FAIL count_wrap: count=%0d ov=%b impulse=%0d update=%b, required 0 1 0 1",
                     cnt_at, ov_at, imp_at, upd_at);
        end
    endtask

    task automatic test_reset_mid();
        logic saw_update;
        do_start(200);
        beat(4, 1, 0, 0);
        beat(4, 1, 0, 0);
        weight_valid = 1'b1;
        weight       = 8'd4;
        spike_in     = 1'b1;
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if ({impulse, update, busy, weight_ready, beat_count, overflow} !== 30'd0) begin
            n_fail++;
            $display("FAIL reset_mid_async: impulse=%h update=%b busy=%b ready=%b count=%0d ov=%b, required all 0",
                     impulse, update, busy, weight_ready, beat_count, overflow);
        end
        weight_valid = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        saw_update = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (update) saw_update = 1'b1;
        end
        n_checks++;
        if (saw_update !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_no_update: update_seen=%b busy=%b, required 0 0", saw_update, busy);
        end
        do_start(7);
        beat(1, 1, 1, 0);
        wait_done();
        n_checks++;
        if (imp_at !== 16'd8 || upd_at !== 1'b1) begin
            n_fail++; $display("FAIL reset_mid_recover: impulse=%0d update=%b, required 8 1", imp_at, upd_at);
        end
    endtask

    task automatic test_back_to_back();
        do_start(10);
        beat(5, 1, 1, 0);
        @(posedge clk); #1;
        n_checks++;
        if (update !== 1'b1 || impulse !== 16'd15) begin
            n_fail++; $display("FAIL b2b_first: update=%b impulse=%0d, required 1 15", update, impulse);
        end
        start   = 1'b1;
        vmem_in = 16'hFF9C;
        @(posedge clk); #1 start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || update !== 1'b0 || impulse !== 16'd15) begin
            n_fail++;
            $display("FAIL b2b_start_taken: busy=%b update=%b impulse=%0d, required 1 0 15", busy, update, impulse);
        end
        beat(-1, 1, 0, 0);
        beat(-2, 1, 1, 0);
        @(negedge clk);
        n_checks++;
        if (impulse !== 16'd15) begin
            n_fail++; $display("FAIL b2b_hold: impulse=%0d, required 15", impulse);
        end
        @(negedge clk);
        n_checks++;
        if (impulse !== 16'hFF99 || update !== 1'b1 || beat_count !== 10'd2) begin
            n_fail++;
            $display("FAIL b2b_second: impulse=%h update=%b count=%0d, required ff99 1 2", impulse, update, beat_count);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_negative();
        test_saturation();
        test_backpressure();
        test_count_wrap();
        test_reset_mid();
        test_back_to_back();
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
